// File: rtl/aes_job_arbiter.sv
// rtl/aes_job_arbiter.sv - round-robin arbiter sharing one multi-cycle AES engine between two requesters
//
// Purpose:
//   Two requesters compete for a single AES engine. The arbiter picks a winner
//   round-robin, latches that job's block/key/mode, launches the engine with a
//   one-cycle start pulse, waits for completion or a timeout and returns the
//   result to the owning requester over a valid/ready handshake.
//
// Ports:
//   clk, rst                       clock; asynchronous active-high reset
//   req_valid[1:0], req_ready[1:0] per-requester job handshake (bit i = requester i)
//   req_mode0/1                    job mode, 1 = encrypt, 0 = decrypt
//   req_data0/1                    128-bit input block
//   req_key0/1                     32*Nk-bit key
//   resp_valid[1:0], resp_ready    per-requester result handshake
//   resp_data                      shared 128-bit result bus, qualified by resp_valid
//   resp_err                       1 = job timed out (resp_data is then 0)
//   core_start                     one-cycle engine launch pulse
//   core_mode/core_data/core_key   latched job driven to the engine
//   core_done, core_result         engine completion pulse and its output
//   busy                           high whenever a job is in progress
//   jobs_done                      wrapping count of successfully completed jobs

module aes_job_arbiter #(
  parameter int Nk      = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic                req_mode0,
  input  logic [127:0]        req_data0,
  input  logic [32*Nk-1:0]    req_key0,
  input  logic                req_mode1,
  input  logic [127:0]        req_data1,
  input  logic [32*Nk-1:0]    req_key1,

  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [127:0]        resp_data,
  output logic                resp_err,

  output logic                core_start,
  output logic                core_mode,
  output logic [127:0]        core_data,
  output logic [32*Nk-1:0]    core_key,
  input  logic                core_done,
  input  logic [127:0]        core_result,

  output logic                busy,
  output logic [CNT_W-1:0]    jobs_done
);

  // Timeout counter only ever needs to reach TIMEOUT-2 (see timeout_hit).
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            rr_ptr;
  logic            owner;
  logic [TW-1:0]   tmo_cnt;

  logic            have_grant;
  logic            grant;
  logic            accept;
  logic            timeout_hit;
  logic            resp_fire;

  // Round-robin choice: the preferred requester wins if it is asking,
  // otherwise the other one gets the slot.
  always_comb begin
    have_grant = |req_valid;
    grant      = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

  assign accept    = (state == S_IDLE) && have_grant;
  assign resp_fire = (state == S_RESP) && resp_ready[owner];

  // The counter is cleared in LAUNCH and advances once per BUSY cycle; the job
  // aborts on the edge where it would reach TIMEOUT-1, so the response appears
  // TIMEOUT cycles after the start pulse.
  assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    core_start = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (have_grant) begin
          req_ready  = grant ? 2'b10 : 2'b01;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        if (core_done || timeout_hit) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ready[owner]) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      tmo_cnt   <= '0;
      core_mode <= 1'b0;
      core_data <= '0;
      core_key  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      jobs_done <= '0;
    end else begin
      if (accept) begin
        owner     <= grant;
        core_mode <= grant ? req_mode1 : req_mode0;
        core_data <= grant ? req_data1 : req_data0;
        core_key  <= grant ? req_key1  : req_key0;
      end

      if (state == S_LAUNCH) begin
        tmo_cnt <= '0;
      end

      if (state == S_BUSY) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        // Completion takes priority over a timeout landing on the same cycle.
        if (core_done) begin
          resp_data <= core_result;
          resp_err  <= 1'b0;
          jobs_done <= jobs_done + CNT_W'(1);
        end else if (timeout_hit) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end

      // Next arbitration favours whoever was not just served.
      if (resp_fire) begin
        rr_ptr <= ~owner;
      end
    end
  end

endmodule
